// File: rtl/rast_tri_feeder_if.sv
// Bus bundles for rast_tri_feeder:
//   rast_geom_if - geometry-stage push side (triangle/quad entries, valid/ready).
//   rast_r10_if  - rasteriser R10 triangle bus (valid, halt_RnnnnL back-pressure).
// The master modport is the side that launches the data.

interface rast_geom_if #(
   parameter int SIGFIG = 24,
   parameter int VERTS  = 4,
   parameter int AXIS   = 3,
   parameter int COLORS = 3
);
   logic signed [SIGFIG-1:0] in_tri_S   [VERTS][AXIS];
   logic        [SIGFIG-1:0] in_color_U [COLORS];
   logic                     in_quad_H;
   logic                     in_valid_H;
   logic                     in_ready_H;

   modport master (
      output in_tri_S, in_color_U, in_quad_H, in_valid_H,
      input  in_ready_H
   );
   modport slave (
      input  in_tri_S, in_color_U, in_quad_H, in_valid_H,
      output in_ready_H
   );
endinterface

interface rast_r10_if #(
   parameter int SIGFIG = 24,
   parameter int AXIS   = 3,
   parameter int COLORS = 3
);
   logic signed [SIGFIG-1:0] tri_R10S   [3][AXIS];
   logic        [SIGFIG-1:0] color_R10U [COLORS];
   logic                     validTri_R10H;
   logic                     halt_RnnnnL;

   modport master (
      output tri_R10S, color_R10U, validTri_R10H,
      input  halt_RnnnnL
   );
   modport slave (
      input  tri_R10S, color_R10U, validTri_R10H,
      output halt_RnnnnL
   );
endinterface

// File: rtl/rast_tri_feeder.sv
// rast_tri_feeder: buffers triangle/quad entries from the geometry stage in a
// DEPTH-entry FIFO and presents one three-vertex triangle per transfer on the
// rasteriser R10 bus. Also holds the screen/MSAA configuration registers.
// Optional macro RAST_FEEDER_QUAD_EN: when defined, quad entries are split
// into (v0,v1,v2) then (v0,v2,v3) through the EMIT1 state; otherwise every
// entry yields exactly one triangle and in_quad_H / vertex slot 3 are ignored.

module rast_tri_feeder #(
   parameter int SIGFIG = 24,
   parameter int RADIX  = 10,
   parameter int VERTS  = 4,
   parameter int AXIS   = 3,
   parameter int COLORS = 3,
   parameter int DEPTH  = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   rast_geom_if.slave                     geom,
   rast_r10_if.master                     r10,
   input  logic signed [SIGFIG-1:0]       cfg_screen_w_S,
   input  logic signed [SIGFIG-1:0]       cfg_screen_h_S,
   input  logic        [6:0]              cfg_msaa_U,
   input  logic                           cfg_load_H,
   output logic                           cfg_err_H,
   output logic signed [1:0][SIGFIG-1:0]  screen_RnnnnS,
   output logic        [3:0]              subSample_RnnnnU,
   output logic        [1:0]              ss_w_lg2_RnnnnS,
   output logic        [15:0]             tri_count_U,
   output logic                           idle_H
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]        FULL_CNT   = CNT_W'(DEPTH);
   localparam logic signed [SIGFIG-1:0] SCREEN_RST = SIGFIG'(512 << RADIX);

`ifdef RAST_FEEDER_QUAD_EN
   localparam int SLOTS = VERTS;
   typedef enum logic {EMIT0 = 1'b0, EMIT1 = 1'b1} state_t;
`else
   localparam int SLOTS = 3;
   typedef enum logic {EMIT0 = 1'b0} state_t;
`endif

   // FIFO storage and bookkeeping
   logic signed [SIGFIG-1:0] mem_tri   [DEPTH][SLOTS][AXIS];
   logic        [SIGFIG-1:0] mem_color [DEPTH][COLORS];
   logic [PTR_W-1:0]         wr_ptr, rd_ptr;
   logic [CNT_W-1:0]         count;
   logic                     fifo_empty;
   logic                     push, pop, load, sel_alt;
   logic                     head_quad;
   state_t                   state, state_nxt;

   // Config decode
   logic                     msaa_ok;
   logic [3:0]               ss_dec;
   logic [1:0]               lg2_dec;

   assign fifo_empty      = (count == '0);
   assign geom.in_ready_H = (count < FULL_CNT);
   assign push            = geom.in_valid_H && geom.in_ready_H;
   assign idle_H          = fifo_empty && !r10.validTri_R10H;

`ifdef RAST_FEEDER_QUAD_EN
   logic mem_quad [DEPTH];
   assign head_quad = mem_quad[rd_ptr];

   // Quad flag storage, written alongside the vertex data.
   always_ff @(posedge clk) begin
      if (push) mem_quad[wr_ptr] <= geom.in_quad_H;
   end
`else
   logic unused_in;
   assign head_quad = 1'b0;

   // Quad flag and vertex slots above 2 have no effect without quad splitting.
   always_comb begin
      unused_in = geom.in_quad_H;
      for (int v = 3; v < VERTS; v++)
         for (int a = 0; a < AXIS; a++)
            unused_in = unused_in ^ (^geom.in_tri_S[v][a]);
   end
`endif

   // Entry storage, written at the write pointer on every accepted push.
   // NOTE: the storage array has no reset; count and pointers alone decide
   // which entries are live, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (push) begin
         for (int v = 0; v < SLOTS; v++)
            for (int a = 0; a < AXIS; a++)
               mem_tri[wr_ptr][v][a] <= geom.in_tri_S[v][a];
         for (int c = 0; c < COLORS; c++)
            mem_color[wr_ptr][c] <= geom.in_color_U[c];
      end
   end

   // Pointers wrap modulo DEPTH (power of two); a same-cycle push and pop
   // leaves the occupancy unchanged.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Split FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= EMIT0;
      else      state <= state_nxt;
   end

   // Split FSM next state: the output register loads only while the
   // rasteriser is accepting, so a halted bus freezes everything.
   // NOTE: every signal driven here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      pop       = 1'b0;
      sel_alt   = 1'b0;
      if (r10.halt_RnnnnL && !fifo_empty) begin
         load = 1'b1;
`ifdef RAST_FEEDER_QUAD_EN
         case (state)
            EMIT0: begin
               if (head_quad) state_nxt = EMIT1;
               else           pop       = 1'b1;
            end
            EMIT1: begin
               sel_alt   = 1'b1;
               pop       = 1'b1;
               state_nxt = EMIT0;
            end
            default: state_nxt = EMIT0;
         endcase
`else
         pop = head_quad | 1'b1;
`endif
      end
   end

   // R10 output register: (v0,v1,v2) normally, (v0,v2,v3) for a quad's
   // second half; holds while halt_RnnnnL is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r10.validTri_R10H <= 1'b0;
         for (int s = 0; s < 3; s++)
            for (int a = 0; a < AXIS; a++)
               r10.tri_R10S[s][a] <= '0;
         for (int c = 0; c < COLORS; c++)
            r10.color_R10U[c] <= '0;
      end else if (r10.halt_RnnnnL) begin
         r10.validTri_R10H <= load;
         if (load) begin
            for (int a = 0; a < AXIS; a++) begin
               r10.tri_R10S[0][a] <= mem_tri[rd_ptr][0][a];
               r10.tri_R10S[1][a] <= sel_alt ? mem_tri[rd_ptr][2][a]
                                             : mem_tri[rd_ptr][1][a];
               r10.tri_R10S[2][a] <= sel_alt ? mem_tri[rd_ptr][SLOTS-1][a]
                                             : mem_tri[rd_ptr][2][a];
            end
            for (int c = 0; c < COLORS; c++)
               r10.color_R10U[c] <= mem_color[rd_ptr][c];
         end
      end
   end

   // Transfer counter, wraps at 16 bits.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                        tri_count_U <= '0;
      else if (r10.validTri_R10H && r10.halt_RnnnnL)   tri_count_U <= tri_count_U + 16'd1;
   end

   // MSAA decode: legal sample counts map to a one-hot interval and log2 width.
   always_comb begin
      msaa_ok = 1'b1;
      ss_dec  = 4'b0100;
      lg2_dec = 2'd1;
      case (cfg_msaa_U)
         7'd1:    begin ss_dec = 4'b1000; lg2_dec = 2'd0; end
         7'd4:    begin ss_dec = 4'b0100; lg2_dec = 2'd1; end
         7'd16:   begin ss_dec = 4'b0010; lg2_dec = 2'd2; end
         7'd64:   begin ss_dec = 4'b0001; lg2_dec = 2'd3; end
         default: msaa_ok = 1'b0;
      endcase
   end

   // Config registers: a load is taken only while idle with a legal MSAA
   // value; anything else latches the sticky error and changes nothing.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         screen_RnnnnS[0] <= SCREEN_RST;
         screen_RnnnnS[1] <= SCREEN_RST;
         subSample_RnnnnU <= 4'b0100;
         ss_w_lg2_RnnnnS  <= 2'd1;
         cfg_err_H        <= 1'b0;
      end else if (cfg_load_H) begin
         if (idle_H && msaa_ok) begin
            screen_RnnnnS[0] <= cfg_screen_w_S;
            screen_RnnnnS[1] <= cfg_screen_h_S;
            subSample_RnnnnU <= ss_dec;
            ss_w_lg2_RnnnnS  <= lg2_dec;
         end else begin
            cfg_err_H <= 1'b1;
         end
      end
   end

endmodule
